// File: rtl/sram_burst_reader.sv
// sram_burst_reader: burst reader on RAM port B feeding a valid/ready stream through a small FIFO
module sram_burst_reader #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 64,
    parameter int ADDR_SIZE = 8,
    parameter int LEN_SIZE  = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [LEN_SIZE-1:0]  length,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic                 sram_rwenable,
    input  logic [RAM_WIDTH-1:0] sram_rdata,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_q, state_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, valid_q, valid_d;
    logic [ADDR_SIZE-1:0] sram_addr_q, sram_addr_d, addr_q, addr_d;
    logic [LEN_SIZE-1:0] rem_q, rem_d;
    logic rd1_q, rd1_d, rd2_q, rd2_d, last1_q, last1_d, last2_q, last2_d;
    logic [BUF_DEPTH-1:0][RAM_WIDTH-1:0] data_q, data_d;
    logic [BUF_DEPTH-1:0] lst_q, lst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr;
    logic pop, issue;
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (32'(a) == RAM_DEPTH - 1) ? '0 : a + 1'b1;
    endfunction
    always_comb begin
        state_d = state_q;
        busy_d = busy_q;
        done_d = 1'b0;
        err_d = 1'b0;
        sram_addr_d = sram_addr_q;
        addr_d = addr_q;
        rem_d = rem_q;
        rd1_d = 1'b0;
        last1_d = 1'b0;
        rd2_d = rd1_q;
        last2_d = last1_q;
        pop = valid_q & out_ready;
        // reads in flight are reserved against buffer space so a stalled consumer never overflows it
        issue = state_q == ISSUE && (32'(cnt_q) + 32'(rd1_q) + 32'(rd2_q) < BUF_DEPTH);
        if (state_q == IDLE && start) begin
            if (32'(start_addr) >= RAM_DEPTH) err_d = 1'b1;
            else if (length == '0) done_d = 1'b1;
            else begin
                state_d = (length == LEN_SIZE'(1)) ? DRAIN : ISSUE;
                busy_d = 1'b1;
                rd1_d = 1'b1;
                last1_d = length == LEN_SIZE'(1);
                sram_addr_d = start_addr;
                addr_d = next_addr(start_addr);
                rem_d = length - 1'b1;
            end
        end
        if (issue) begin
            rd1_d = 1'b1;
            last1_d = rem_q == LEN_SIZE'(1);
            sram_addr_d = addr_q;
            addr_d = next_addr(addr_q);
            rem_d = rem_q - 1'b1;
            state_d = (rem_q == LEN_SIZE'(1)) ? DRAIN : ISSUE;
        end
        if (state_q == DRAIN && pop && lst_q[0]) begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        wr = AW'(cnt_q - CW'(pop));
        data_d = pop ? data_q >> RAM_WIDTH : data_q;
        lst_d = pop ? lst_q >> 1 : lst_q;
        if (rd2_q) begin
            data_d[wr] = sram_rdata;
            lst_d[wr] = last2_q;
        end
        cnt_d = cnt_q + CW'(rd2_q) - CW'(pop);
        valid_d = cnt_d != '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            valid_q <= 1'b0;
            sram_addr_q <= '0;
            addr_q <= '0;
            rem_q <= '0;
            rd1_q <= 1'b0;
            rd2_q <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            data_q <= '0;
            lst_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            valid_q <= valid_d;
            sram_addr_q <= sram_addr_d;
            addr_q <= addr_d;
            rem_q <= rem_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            data_q <= data_d;
            lst_q <= lst_d;
            cnt_q <= cnt_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign sram_addr = sram_addr_q;
    assign sram_rwenable = 1'b0;
    assign out_data = data_q[0];
    assign out_valid = valid_q;
    assign out_last = valid_q & lst_q[0];
endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
Burst read engine that acts as the reader on port B of dual_port_sram, while a writer agent owns port A. On a start command it issues a run of consecutive reads beginning at a start address. It returns the words in order on a valid/ready stream, and it tolerates downstream backpressure through a small internal buffer. It never writes the RAM.

Parameters:
RAM_WIDTH, 8, data word width in bits
RAM_DEPTH, 64, number of words in the attached RAM; addresses wrap modulo this value
ADDR_SIZE, 8, address bus width
LEN_SIZE, 8, burst length field width
BUF_DEPTH, 4, output buffer entries (power of 2, ≥4)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  burst request, sampled only when busy=0
start_addr  in  ADDR_SIZE  first word address
length  in  LEN_SIZE  number of words to read (0 allowed)
busy  out  1  burst in progress
done  out  1  one-cycle pulse when burst completes
err  out  1  one-cycle pulse when a start is rejected
sram_addr  out  ADDR_SIZE  to RAM port-B address
sram_rwenable  out  1  to RAM port-B rwenable; constant 0 (read)
sram_rdata  in  RAM_WIDTH  from RAM port-B outputData
out_data  out  RAM_WIDTH  head-of-buffer word
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid & out_ready
out_last  out  1  qualifies the final word of a burst

Behaviour:
- RAM read timing: the RAM registers outputData at the edge after the address is presented, so read latency is 1 clk. The reader captures sram_rdata into the buffer on the following edge.
- Reset (reset=0 at an edge): state IDLE; busy=0, done=0, err=0, out_valid=0, out_last=0, out_data=0, sram_addr=0, sram_rwenable=0. The buffer and in-flight tracking are cleared. Reset mid-burst aborts the burst with no done pulse, and outstanding RAM data is discarded.
- FSM states:
  - IDLE: on start=1 with start_addr<RAM_DEPTH and length>0, go to ISSUE, set busy=1, and latch the address and remaining count.
  - IDLE, length=0: no reads are issued; done pulses the next cycle; stay in IDLE.
  - IDLE, start_addr≥RAM_DEPTH: err pulses for 1 cycle; stay in IDLE.
  - ISSUE: one read per cycle while (buffer occupancy + in-flight reads) < BUF_DEPTH. Each issued read drives sram_addr to the current address, then advances the address by 1, wrapping from RAM_DEPTH-1 to 0. After the last read is issued, go to DRAIN.
  - DRAIN: wait until every issued word has been handshaken on the output, then go to IDLE.
- Completion: busy deasserts and done pulses in the cycle after the handshake of the word with out_last=1.
- start while busy=1 is ignored: no err, no effect.
- Issue timing: after the start-sampling edge E0, sram_addr=start_addr. Data enters the buffer at E2, and out_valid=1 in the cycle after E2.
- Throughput: with out_ready held at 1, one word per clk is sustained with no bubbles.
- Backpressure: out_data and out_valid hold stable while out_valid=1 and out_ready=0. There is no overflow and no dropped or duplicated words. The buffer is a FIFO with a registered head.
- out_last=1 only together with out_valid, and only on the final word of the burst.
- Length counter: width LEN_SIZE. The maximum burst is 2^LEN_SIZE-1 words and may exceed RAM_DEPTH, in which case addresses simply wrap.
- sram_addr holds its last value while no read is being issued.

Test Plan:
- Preload addr 1..8 = 16..23 via port A. start_addr=1, length=8, out_ready=1 → out_data 16,17,…,23 on 8 consecutive cycles. First out_valid 2 clks after the start edge. out_last on 23. done 1 clk after it. busy high throughout.
- Wrap: preload addr 62=0xAA, 63=0xBB, 0=0xCC. start_addr=62, length=3 → sram_addr sequence 62,63,0; out_data AA,BB,CC.
- Backpressure: burst of 8 from addr 1 with out_ready toggled 1,0,0,1,0,… → exactly 16..23 in order, out_data stable while stalled, occupancy never exceeds 4, sram_rwenable never 1.
- Edge commands: length=0 → done pulse only, no out_valid. start_addr=64 → err pulse, busy stays 0. start asserted mid-burst → ignored.
- Reset mid-burst: assert reset=0 after 3 words are delivered → next cycle out_valid=0, busy=0, no done. A new burst after release returns correct data.
